// File: rtl/ctrl_pipe.sv
// ctrl_pipe: control-side pipeline between ID and the EX/MEM/WB datapath.
// Stages the ID control bundle {wb,m,exe} and register fields through ID/EX,
// EX/MEM and MEM/WB, detects load-use and data hazards, inserts bubbles,
// applies branch flush and produces ALU operand forwarding selects.
// Optional feature: define FORWARDING_EN to enable operand forwarding; without
// it the block stalls on every in-flight EX/MEM writer dependency instead.
module ctrl_pipe #(
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    id_wb,
  input  logic [2:0]    id_m,
  input  logic [3:0]    id_exe,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          flush,
  output logic          hazard_stall,
  output logic          ex_regdst,
  output logic          ex_alusrc,
  output logic [1:0]    ex_aluop,
  output logic [RW-1:0] ex_rs,
  output logic [RW-1:0] ex_rt,
  output logic          mem_branch,
  output logic          mem_memread,
  output logic          mem_memwrite,
  output logic [RW-1:0] mem_dst,
  output logic          wb_regwrite,
  output logic          wb_memtoreg,
  output logic [RW-1:0] wb_dst,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b
);

  // ID/EX register fields
  logic [1:0]    ex_wb;
  logic [2:0]    ex_m;
  logic [3:0]    ex_exe;
  logic [RW-1:0] ex_rd;

  // EX/MEM register fields
  logic [1:0]    mem_wb;
  logic [2:0]    mem_m;

  // MEM/WB register fields
  logic [1:0]    wb_wb;

  // EX-stage destination, chosen before it is latched into EX/MEM
  logic [RW-1:0] ex_dst;
  logic          load_use;

  assign ex_dst = ex_exe[0] ? ex_rd : ex_rt;

  assign ex_regdst    = ex_exe[0];
  assign ex_aluop     = ex_exe[2:1];
  assign ex_alusrc    = ex_exe[3];
  assign mem_branch   = mem_m[0];
  assign mem_memread  = mem_m[1];
  assign mem_memwrite = mem_m[2];
  assign wb_regwrite  = wb_wb[0];
  assign wb_memtoreg  = wb_wb[1];

  // ID/EX stage: load from ID, or a zero bubble on flush or stall
  always_ff @(posedge clk) begin
    if (rst || flush || hazard_stall) begin
      ex_wb  <= '0;
      ex_m   <= '0;
      ex_exe <= '0;
      ex_rs  <= '0;
      ex_rt  <= '0;
      ex_rd  <= '0;
    end else begin
      ex_wb  <= id_wb;
      ex_m   <= id_m;
      ex_exe <= id_exe;
      ex_rs  <= id_rs;
      ex_rt  <= id_rt;
      ex_rd  <= id_rd;
    end
  end

  // EX/MEM stage: the instruction in EX is killed by a taken branch
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      mem_wb  <= '0;
      mem_m   <= '0;
      mem_dst <= '0;
    end else begin
      mem_wb  <= ex_wb;
      mem_m   <= ex_m;
      mem_dst <= ex_dst;
    end
  end

  // MEM/WB stage: the branch resolves in MEM, so MEM always retires into WB
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_wb  <= '0;
      wb_dst <= '0;
    end else begin
      wb_wb  <= mem_wb;
      wb_dst <= mem_dst;
    end
  end

  // Hazard detection and forwarding selects; register 0 is never a dependency
  always_comb begin
    load_use     = ex_m[1] && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    hazard_stall = 1'b0;
    fwd_a        = 2'b00;
    fwd_b        = 2'b00;
`ifdef FORWARDING_EN
    hazard_stall = load_use && !flush;
    if (mem_wb[0] && (mem_dst != '0) && (mem_dst == ex_rs))
      fwd_a = 2'b10;
    else if (wb_wb[0] && (wb_dst != '0) && (wb_dst == ex_rs))
      fwd_a = 2'b01;
    if (mem_wb[0] && (mem_dst != '0) && (mem_dst == ex_rt))
      fwd_b = 2'b10;
    else if (wb_wb[0] && (wb_dst != '0) && (wb_dst == ex_rt))
      fwd_b = 2'b01;
`else
    hazard_stall = !flush && (load_use
      || (ex_wb[0] && (ex_dst != '0) && ((ex_dst == id_rs) || (ex_dst == id_rt)))
      || (mem_wb[0] && (mem_dst != '0) && ((mem_dst == id_rs) || (mem_dst == id_rt))));
`endif
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed scenarios plus randomized traffic for ctrl_pipe,
// checked every cycle against an instruction-level model of the pipeline.
// Honours FORWARDING_EN in the same way as the design.
module tb_ctrl_pipe;

  localparam int RW = 5;

  logic          clk;
  logic          rst;
  logic [1:0]    id_wb;
  logic [2:0]    id_m;
  logic [3:0]    id_exe;
  logic [RW-1:0] id_rs, id_rt, id_rd;
  logic          flush;
  logic          hazard_stall;
  logic          ex_regdst, ex_alusrc;
  logic [1:0]    ex_aluop;
  logic [RW-1:0] ex_rs, ex_rt;
  logic          mem_branch, mem_memread, mem_memwrite;
  logic [RW-1:0] mem_dst;
  logic          wb_regwrite, wb_memtoreg;
  logic [RW-1:0] wb_dst;
  logic [1:0]    fwd_a, fwd_b;

  int passed = 0;
  int total  = 0;

  ctrl_pipe #(.RW(RW)) dut (
    .clk(clk), .rst(rst),
    .id_wb(id_wb), .id_m(id_m), .id_exe(id_exe),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .flush(flush),
    .hazard_stall(hazard_stall),
    .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
    .ex_rs(ex_rs), .ex_rt(ex_rt),
    .mem_branch(mem_branch), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_dst(mem_dst),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_dst(wb_dst),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  // free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // whole instruction as it travels down the pipe; a bubble is all zeros
  typedef struct packed {
    logic [1:0]    wb;
    logic [2:0]    m;
    logic [3:0]    exe;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
  } instr_t;

  instr_t pipe [3];   // 0 = EX, 1 = MEM, 2 = WB
  logic   model_ok   = 1'b0;
  logic   last_stall = 1'b0;

  function automatic logic [RW-1:0] dst_of(instr_t i);
    return i.exe[0] ? i.rd : i.rt;
  endfunction

  function automatic logic writes_to(instr_t i, logic [RW-1:0] r);
    return i.wb[0] && (dst_of(i) != 0) && (dst_of(i) == r);
  endfunction

  function automatic logic model_stall();
    logic s;
    s = pipe[0].m[1] && (pipe[0].rt != 0) && ((pipe[0].rt == id_rs) || (pipe[0].rt == id_rt));
`ifndef FORWARDING_EN
    for (int k = 0; k < 2; k++)
      if (writes_to(pipe[k], id_rs) || writes_to(pipe[k], id_rt)) s = 1'b1;
`endif
    return s && !flush;
  endfunction

  function automatic logic [1:0] model_fwd(logic [RW-1:0] r);
`ifdef FORWARDING_EN
    if (writes_to(pipe[1], r)) return 2'b10;
    if (writes_to(pipe[2], r)) return 2'b01;
`endif
    return 2'b00;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input logic r, input logic [1:0] wb, input logic [2:0] m,
                               input logic [3:0] exe, input logic [RW-1:0] rs,
                               input logic [RW-1:0] rt, input logic [RW-1:0] rd,
                               input logic fl);
    rst = r; id_wb = wb; id_m = m; id_exe = exe;
    id_rs = rs; id_rt = rt; id_rd = rd; flush = fl;
  endtask

  task automatic nop();
    applyStimulus(1'b0, 2'b00, 3'b000, 4'b0000, 0, 0, 0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitCheck();
    @(negedge clk);
    #1;
  endtask

  // model advance: one instruction-level shift per rising edge
  always @(posedge clk) begin
    instr_t id_i;
    logic   st;
    id_i = {id_wb, id_m, id_exe, id_rs, id_rt, id_rd};
    if (rst) begin
      for (int k = 0; k < 3; k++) pipe[k] = '0;
      last_stall = 1'b0;
    end else begin
      st = model_stall();
      pipe[2] = pipe[1];
      pipe[1] = flush ? '0 : pipe[0];
      pipe[0] = (flush || st) ? '0 : id_i;
      last_stall = st;
    end
    model_ok = 1'b1;
  end

  // compare process: every output against the model, every cycle
  always @(negedge clk) begin
    if (model_ok) begin
      checkOutput("hazard_stall", 64'(hazard_stall), 64'(model_stall()));
      checkOutput("ex_ctrl", 64'({ex_regdst, ex_alusrc, ex_aluop}),
                  64'({pipe[0].exe[0], pipe[0].exe[3], pipe[0].exe[2:1]}));
      checkOutput("ex_regs", 64'({ex_rs, ex_rt}), 64'({pipe[0].rs, pipe[0].rt}));
      checkOutput("mem_ctrl", 64'({mem_branch, mem_memread, mem_memwrite, mem_dst}),
                  64'({pipe[1].m[0], pipe[1].m[1], pipe[1].m[2], dst_of(pipe[1])}));
      checkOutput("wb_ctrl", 64'({wb_regwrite, wb_memtoreg, wb_dst}),
                  64'({pipe[2].wb[0], pipe[2].wb[1], dst_of(pipe[2])}));
      checkOutput("fwd_a", 64'(fwd_a), 64'(model_fwd(pipe[0].rs)));
      checkOutput("fwd_b", 64'(fwd_b), 64'(model_fwd(pipe[0].rt)));
    end
  end

  // directed scenarios, then randomized traffic
  initial begin
    // reset held for two cycles with nonzero inputs
    applyStimulus(1'b1, 2'b11, 3'b111, 4'b1111, 5, 5, 5, 1'b0);
    tick();
    waitCheck();
    checkOutput("reset_all_zero_1", {hazard_stall, ex_regdst, ex_alusrc, ex_aluop, ex_rs, ex_rt,
                mem_branch, mem_memread, mem_memwrite, mem_dst, wb_regwrite, wb_memtoreg,
                wb_dst, fwd_a, fwd_b}, 64'd0);
    tick();
    waitCheck();
    checkOutput("reset_all_zero_2", {hazard_stall, ex_regdst, ex_alusrc, ex_aluop, ex_rs, ex_rt,
                mem_branch, mem_memread, mem_memwrite, mem_dst, wb_regwrite, wb_memtoreg,
                wb_dst, fwd_a, fwd_b}, 64'd0);
    tick();
    nop();
    repeat (3) tick();

    // propagation of an R-type through all stages
    applyStimulus(1'b0, 2'b01, 3'b000, 4'b0101, 1, 2, 3, 1'b0);
    tick();
    nop();
    waitCheck();
    checkOutput("prop_ex_regdst", 64'(ex_regdst), 64'd1);
    checkOutput("prop_ex_aluop", 64'(ex_aluop), 64'd2);
    tick();
    waitCheck();
    checkOutput("prop_mem_dst", 64'(mem_dst), 64'd3);
    tick();
    waitCheck();
    checkOutput("prop_wb", 64'({wb_regwrite, wb_dst}), 64'({1'b1, 5'd3}));
    repeat (3) tick();

    // load-use: LW rt=5 followed by ADD rs=5
    applyStimulus(1'b0, 2'b11, 3'b010, 4'b1000, 1, 5, 0, 1'b0);
    tick();
    applyStimulus(1'b0, 2'b01, 3'b000, 4'b0101, 5, 6, 7, 1'b0);
    waitCheck();
    checkOutput("lu_stall_first", 64'(hazard_stall), 64'd1);
    tick();
    waitCheck();
    checkOutput("lu_bubble_ex", 64'({ex_regdst, ex_alusrc, ex_aluop}), 64'd0);
`ifdef FORWARDING_EN
    checkOutput("lu_stall_one_cycle", 64'(hazard_stall), 64'd0);
    tick();
    nop();
    waitCheck();
    checkOutput("lu_fwd_a_wb", 64'(fwd_a), 64'd1);
`else
    checkOutput("lu_stall_second", 64'(hazard_stall), 64'd1);
    tick();
    waitCheck();
    checkOutput("lu_stall_released", 64'(hazard_stall), 64'd0);
    tick();
    nop();
    waitCheck();
    checkOutput("lu_fwd_a_none", 64'(fwd_a), 64'd0);
`endif
    checkOutput("lu_add_in_ex", 64'(ex_rs), 64'd5);
    repeat (3) tick();

`ifdef FORWARDING_EN
    // EX/MEM forward, then the same pattern through register 0
    applyStimulus(1'b0, 2'b01, 3'b000, 4'b0101, 1, 2, 4, 1'b0);
    tick();
    applyStimulus(1'b0, 2'b01, 3'b000, 4'b0101, 4, 4, 8, 1'b0);
    tick();
    nop();
    waitCheck();
    checkOutput("fwd_mem_ab", 64'({fwd_a, fwd_b}), 64'b1010);
    repeat (3) tick();
    applyStimulus(1'b0, 2'b01, 3'b000, 4'b0101, 1, 2, 0, 1'b0);
    tick();
    applyStimulus(1'b0, 2'b01, 3'b000, 4'b0101, 0, 0, 8, 1'b0);
    tick();
    nop();
    waitCheck();
    checkOutput("fwd_r0_ab", 64'({fwd_a, fwd_b}), 64'b0000);
`else
    // dependent instruction directly behind its producer stalls twice
    applyStimulus(1'b0, 2'b01, 3'b000, 4'b0101, 1, 2, 4, 1'b0);
    tick();
    applyStimulus(1'b0, 2'b01, 3'b000, 4'b0101, 4, 9, 8, 1'b0);
    waitCheck();
    checkOutput("dep_stall_1", 64'(hazard_stall), 64'd1);
    tick();
    waitCheck();
    checkOutput("dep_stall_2", 64'({hazard_stall, fwd_a}), 64'b100);
    tick();
    waitCheck();
    checkOutput("dep_stall_done", 64'(hazard_stall), 64'd0);
    tick();
    nop();
    waitCheck();
    checkOutput("dep_fwd_none", 64'({ex_rs, fwd_a}), 64'({5'd4, 2'b00}));
`endif
    repeat (3) tick();

    // flush beats a pending load-use stall
    applyStimulus(1'b0, 2'b01, 3'b001, 4'b0101, 1, 2, 9, 1'b0);
    tick();
    applyStimulus(1'b0, 2'b11, 3'b010, 4'b1000, 1, 5, 0, 1'b0);
    tick();
    applyStimulus(1'b0, 2'b01, 3'b000, 4'b0101, 5, 6, 7, 1'b1);
    waitCheck();
    checkOutput("flush_no_stall", 64'(hazard_stall), 64'd0);
    tick();
    nop();
    waitCheck();
    checkOutput("flush_ex_zero", 64'({ex_regdst, ex_alusrc, ex_aluop}), 64'd0);
    checkOutput("flush_mem_zero", 64'({mem_branch, mem_memread, mem_memwrite, mem_dst}), 64'd0);
    checkOutput("flush_wb_kept", 64'({wb_regwrite, wb_dst}), 64'({1'b1, 5'd9}));
    repeat (3) tick();

    // randomized traffic; ID is held while the model predicts a stall
    begin
      logic [1:0]    r_wb  = '0;
      logic [2:0]    r_m   = '0;
      logic [3:0]    r_exe = '0;
      logic [RW-1:0] r_rs  = '0, r_rt = '0, r_rd = '0;
      for (int c = 0; c < 3000; c++) begin
        tick();
        if (!last_stall) begin
          r_wb  = 2'($urandom);
          r_m   = 3'($urandom);
          r_exe = 4'($urandom);
          r_rs  = RW'($urandom_range(0, 7));
          r_rt  = RW'($urandom_range(0, 7));
          r_rd  = RW'($urandom_range(0, 7));
        end
        applyStimulus($urandom_range(0, 199) == 0, r_wb, r_m, r_exe, r_rs, r_rt, r_rd,
                      $urandom_range(0, 9) == 0);
      end
    end
    tick();
    nop();
    repeat (2) tick();

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
